main_control_fsm: RTL

Multi-cycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps. Drives every datapath enable and mux select, and produces the 3-bit `alu_op` consumed by the ALU control decoder. Sits between the instruction register (supplies `opcode`) and the datapath/memory, with a `mem_ready` handshake for variable-latency memory.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/main_ctrl_out_decode.sv | 115 +++++++++++
 rtl/main_control_fsm.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle control path: opcodes,
// ALUOp codes (also used by the ALU control decoder), operand/PC mux
// encodings and the main control state enumeration.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b011;
  localparam logic [2:0] ALUOP_ANDI  = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_ADDI_EXEC = 4'd9,
    ST_ANDI_EXEC = 4'd10,
    ST_IMM_WB    = 4'd11,
    ST_JUMP      = 4'd12
  } state_t;

  // True for every opcode the control unit knows how to sequence.
  function automatic logic opcode_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_BEQ)  ||
           (op == OP_BNE)   || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_LW)    || (op == OP_SW);
  endfunction

endpackage

// File: rtl/main_ctrl_out_decode.sv
// Combinational decode of the control state into datapath enables and
// mux selects. All outputs are forced low while the unit is held in reset.
module main_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       active,
  input  logic       op_bit0,
  input  logic       op_legal,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_op,
  output logic       illegal_op
);

  // Per-state output table; everything defaults to 0.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    pc_source  = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    zero_ext   = 1'b0;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    if (active) begin
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          // IR and PC load only on the cycle the fetch actually completes.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b  = SRCB_IMM_SL;
          illegal_op = ~op_legal;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        ST_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        ST_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_source = PCSRC_ALUOUT;
          // opcode bit 0 separates bne (1) from beq (0).
          branch_eq = ~op_bit0;
          branch_ne = op_bit0;
        end
        ST_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADDI;
        end
        ST_ANDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ANDI;
          zero_ext  = 1'b1;
        end
        ST_IMM_WB: begin
          reg_write = 1'b1;
        end
        ST_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control unit: state register and next-state logic.
// Output generation lives in main_ctrl_out_decode.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   op_legal;

  assign op_legal = opcode_legal(opcode);
  // state_q is already FETCH (0) during reset, so no extra gating needed.
  assign state    = state_q;

  // State register; reset drops straight to FETCH without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
          OP_RTYPE:       state_d = ST_R_EXEC;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_ADDI:        state_d = ST_ADDI_EXEC;
          OP_ANDI:        state_d = ST_ANDI_EXEC;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_IMM_WB;
      ST_ANDI_EXEC: state_d = ST_IMM_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  main_ctrl_out_decode u_out_decode (
    .state      (state_q),
    .active     (rst_n),
    .op_bit0    (opcode[0]),
    .op_legal   (op_legal),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .pc_source  (pc_source),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .zero_ext   (zero_ext),
    .alu_op     (alu_op),
    .illegal_op (illegal_op)
  );

endmodule
